// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the pipeline back end.
//   - F3_* : funct3 encodings of the integer load instructions
//   - wb_state_t : writeback stage state (idle / waiting for load data)
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
// MEM -> WB retirement channel (valid/ready handshake plus instruction fields).
//   mem_valid      MEM presents an instruction
//   mem_ready      WB can accept; transfer = mem_valid & mem_ready
//   mem_rd_addr    destination register
//   mem_reg_write  instruction writes rd
//   mem_is_load    result comes from data memory
//   mem_funct3     load type
//   mem_addr_lo    byte offset of the load address
//   mem_alu_result result for non-load instructions
// master = MEM stage side, slave = writeback stage side.
// -----------------------------------------------------------------------------
interface writeback_stage_if;

  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write;
  logic        mem_is_load;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result;

  modport master (
    output mem_valid, mem_rd_addr, mem_reg_write, mem_is_load,
           mem_funct3, mem_addr_lo, mem_alu_result,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_rd_addr, mem_reg_write, mem_is_load,
           mem_funct3, mem_addr_lo, mem_alu_result,
    output mem_ready
  );

endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load data alignment and sign/zero extension.
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU)
//   addr_lo in  2   byte offset within the word
//   rdata   in  32  raw word-aligned data
//   data    out 32  aligned, extended result
//   err     out 1   misaligned access or unsupported funct3
// Kept free of pipeline state so a store-forwarding path can reuse it.
// -----------------------------------------------------------------------------
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned and infers a latch.
    data     = rdata;
    err      = 1'b0;
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        err  = addr_lo[0];
      end
      F3_LHU: begin
        data = {16'd0, half_sel};
        err  = addr_lo[0];
      end
      F3_LW:  err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage and sole driver of the register file write port.
//   clk, rst_n       clock / asynchronous active-low reset
//   mem              writeback_stage_if.slave, retirement channel from MEM
//   dmem_rvalid      load data valid (single-cycle pulse)
//   dmem_rdata       raw word-aligned load data
//   rd_addr/rd_data  register file write address / data (hold when we=0)
//   we               register file write enable, never set for x0
//   load_pending     a load is waiting for data memory
//   load_rd_addr     rd of the pending load, 0 otherwise
//   load_err         one-cycle pulse: load timeout, misalignment, bad funct3
// Non-loads write one cycle after transfer. Loads park in WB_WAIT_LOAD until
// dmem_rvalid (write one cycle later) or LOAD_TIMEOUT idle cycles elapse.
// LOAD_TIMEOUT must be >= 1.
// -----------------------------------------------------------------------------
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_stage_if.slave   mem,
  input  logic               dmem_rvalid,
  input  logic [31:0]        dmem_rdata,
  output logic [4:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic               we,
  output logic               load_pending,
  output logic [4:0]         load_rd_addr,
  output logic               load_err
);

  localparam int                CNT_W    = $clog2(LOAD_TIMEOUT + 1);
  // Last counter value seen in WB_WAIT_LOAD before the timeout fires.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_lo_q, ld_lo_d;
  logic              ld_rw_q, ld_rw_d;
  logic              we_q, we_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              load_err_q, load_err_d;
  logic              load_pending_q, load_pending_d;

  logic [31:0]       align_data;
  logic              align_err;

  load_align u_load_align (
    .funct3  (ld_f3_q),
    .addr_lo (ld_lo_q),
    .rdata   (dmem_rdata),
    .data    (align_data),
    .err     (align_err)
  );

  // Combinational decode of the state flop; reads 1 while reset holds IDLE.
  assign mem.mem_ready = (state_q == WB_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    ld_rw_d    = ld_rw_q;
    we_d       = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    load_err_d = 1'b0;

    case (state_q)
      WB_IDLE: begin
        // dmem_rvalid is deliberately ignored here: it can only be spurious.
        if (mem.mem_valid) begin
          if (mem.mem_is_load) begin
            state_d = WB_WAIT_LOAD;
            cnt_d   = '0;
            ld_rd_d = mem.mem_rd_addr;
            ld_f3_d = mem.mem_funct3;
            ld_lo_d = mem.mem_addr_lo;
            ld_rw_d = mem.mem_reg_write;
          end else if (mem.mem_reg_write && (mem.mem_rd_addr != 5'd0)) begin
            we_d      = 1'b1;
            rd_addr_d = mem.mem_rd_addr;
            rd_data_d = mem.mem_alu_result;
          end
        end
      end

      WB_WAIT_LOAD: begin
        // rvalid is tested before the counter so data arriving on the
        // expiry cycle still retires normally.
        if (dmem_rvalid) begin
          state_d = WB_IDLE;
          ld_rd_d = 5'd0;
          if (align_err) begin
            load_err_d = 1'b1;
          end else if (ld_rw_q && (ld_rd_q != 5'd0)) begin
            we_d      = 1'b1;
            rd_addr_d = ld_rd_q;
            rd_data_d = align_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d    = WB_IDLE;
          ld_rd_d    = 5'd0;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = WB_IDLE;
    endcase

    load_pending_d = (state_d == WB_WAIT_LOAD);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WB_IDLE;
      cnt_q          <= '0;
      ld_rd_q        <= 5'd0;
      ld_f3_q        <= 3'd0;
      ld_lo_q        <= 2'd0;
      ld_rw_q        <= 1'b0;
      we_q           <= 1'b0;
      rd_addr_q      <= 5'd0;
      rd_data_q      <= 32'd0;
      load_err_q     <= 1'b0;
      load_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ld_rd_q        <= ld_rd_d;
      ld_f3_q        <= ld_f3_d;
      ld_lo_q        <= ld_lo_d;
      ld_rw_q        <= ld_rw_d;
      we_q           <= we_d;
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
      load_err_q     <= load_err_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign we           = we_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;
  assign load_err     = load_err_q;
  assign load_pending = load_pending_q;
  // Cleared whenever the stage leaves WB_WAIT_LOAD, so it reads 0 when idle.
  assign load_rd_addr = ld_rd_q;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Directed bench for writeback_stage. Inputs change and outputs are sampled
// on the falling clock edge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        we;
  logic        load_pending;
  logic [4:0]  load_rd_addr;
  logic        load_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  writeback_stage_if mem_if ();

  writeback_stage #(.LOAD_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mem_if),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .we           (we),
    .load_pending (load_pending),
    .load_rd_addr (load_rd_addr),
    .load_err     (load_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    mem_if.mem_valid      = 1'b0;
    mem_if.mem_is_load    = 1'b0;
    mem_if.mem_reg_write  = 1'b0;
    mem_if.mem_rd_addr    = 5'd0;
    mem_if.mem_funct3     = 3'd0;
    mem_if.mem_addr_lo    = 2'd0;
    mem_if.mem_alu_result = 32'd0;
    dmem_rvalid           = 1'b0;
    dmem_rdata            = 32'd0;
  endtask

  task automatic send_alu(input logic [4:0] rd, input logic [31:0] res, input logic rw);
    mem_if.mem_valid      = 1'b1;
    mem_if.mem_is_load    = 1'b0;
    mem_if.mem_reg_write  = rw;
    mem_if.mem_rd_addr    = rd;
    mem_if.mem_alu_result = res;
  endtask

  task automatic send_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    mem_if.mem_valid      = 1'b1;
    mem_if.mem_is_load    = 1'b1;
    mem_if.mem_reg_write  = 1'b1;
    mem_if.mem_rd_addr    = rd;
    mem_if.mem_funct3     = f3;
    mem_if.mem_addr_lo    = lo;
    mem_if.mem_alu_result = 32'h0;
  endtask

  // Load with one idle wait cycle before rvalid; returns on the falling edge
  // where the write (or error pulse) is visible.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] data);
    send_load(rd, f3, lo);
    step();
    drive_idle();
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = data;
    step();
    drive_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    step();
    step();
    tests_run++;
    if ({we, rd_addr, rd_data, load_pending, load_rd_addr, load_err, mem_if.mem_ready} !==
        {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state got we=%0b rd=%0d data=%h pend=%0b lrd=%0d err=%0b rdy=%0b exp all 0, rdy=1",
               we, rd_addr, rd_data, load_pending, load_rd_addr, load_err, mem_if.mem_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_single();
    send_alu(5'd5, 32'h1234_5678, 1'b1);
    step();
    drive_idle();
    tests_run++;
    if ({we, rd_addr, rd_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL alu_write got we=%0b rd=%0d data=%h exp we=1 rd=5 data=12345678", we, rd_addr, rd_data);
    end
    step();
    tests_run++;
    if (we !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_we_drop got we=%0b exp 0", we);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res [3];
    res[0] = 32'hA5A5_0001;
    res[1] = 32'h5A5A_0002;
    res[2] = 32'h0F0F_0003;
    send_alu(5'd1, res[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) send_alu(5'(i + 2), res[i + 1], 1'b1);
      else drive_idle();
      tests_run++;
      if ({we, rd_addr, rd_data, mem_if.mem_ready} !== {1'b1, 5'(i + 1), res[i], 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_write%0d got we=%0b rd=%0d data=%h rdy=%0b exp we=1 rd=%0d data=%h rdy=1",
                 i, we, rd_addr, rd_data, mem_if.mem_ready, i + 1, res[i]);
      end
    end
  endtask

  task automatic test_load_byte();
    send_load(5'd7, LB, 2'd1);
    step();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({load_pending, load_rd_addr, mem_if.mem_ready, we} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL lb_wait%0d got pend=%0b lrd=%0d rdy=%0b we=%0b exp pend=1 lrd=7 rdy=0 we=0",
                 i, load_pending, load_rd_addr, mem_if.mem_ready, we);
      end
      if (i == 2) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000_8000;
      end
      step();
    end
    drive_idle();
    tests_run++;
    if ({we, rd_addr, rd_data, load_pending, load_rd_addr, mem_if.mem_ready} !==
        {1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 5'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL lb_write got we=%0b rd=%0d data=%h pend=%0b lrd=%0d rdy=%0b exp we=1 rd=7 data=ffffff80 pend=0 lrd=0 rdy=1",
               we, rd_addr, rd_data, load_pending, load_rd_addr, mem_if.mem_ready);
    end
  endtask

  task automatic test_load_align();
    logic [2:0]  f3   [4];
    logic [1:0]  lo   [4];
    logic [31:0] raw  [4];
    logic [31:0] exp_d[4];
    f3[0] = LHU; lo[0] = 2'd2; raw[0] = 32'hBEEF_1234; exp_d[0] = 32'h0000_BEEF;
    f3[1] = LH;  lo[1] = 2'd2; raw[1] = 32'hBEEF_1234; exp_d[1] = 32'hFFFF_BEEF;
    f3[2] = LBU; lo[2] = 2'd3; raw[2] = 32'h9A00_0000; exp_d[2] = 32'h0000_009A;
    f3[3] = LW;  lo[3] = 2'd0; raw[3] = 32'hCAFE_BABE; exp_d[3] = 32'hCAFE_BABE;
    for (int i = 0; i < 4; i++) begin
      do_load(5'(i + 3), f3[i], lo[i], raw[i]);
      tests_run++;
      if ({we, rd_addr, rd_data, load_err} !== {1'b1, 5'(i + 3), exp_d[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL align%0d got we=%0b rd=%0d data=%h err=%0b exp we=1 rd=%0d data=%h err=0",
                 i, we, rd_addr, rd_data, load_err, i + 3, exp_d[i]);
      end
    end
  endtask

  task automatic test_no_write_cases();
    send_alu(5'd0, 32'hDEAD_BEEF, 1'b1);
    step();
    send_alu(5'd6, 32'h1111_2222, 1'b0);
    tests_run++;
    if (we !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_rd0 got we=%0b exp 0", we);
    end
    step();
    drive_idle();
    tests_run++;
    if (we !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_no_regwrite got we=%0b exp 0", we);
    end
    do_load(5'd0, LW, 2'd0, 32'h7777_7777);
    tests_run++;
    if ({we, load_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL load_rd0 got we=%0b err=%0b exp we=0 err=0", we, load_err);
    end
    do_load(5'd9, LW, 2'd1, 32'h7777_7777);
    tests_run++;
    if ({we, load_err} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lw_misaligned got we=%0b err=%0b exp we=0 err=1", we, load_err);
    end
    step();
    tests_run++;
    if (load_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_one_cycle got err=%0b exp 0", load_err);
    end
    do_load(5'd9, LH, 2'd1, 32'h7777_7777);
    tests_run++;
    if ({we, load_err} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lh_misaligned got we=%0b err=%0b exp we=0 err=1", we, load_err);
    end
    do_load(5'd9, 3'b011, 2'd0, 32'h7777_7777);
    tests_run++;
    if ({we, load_err} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bad_funct3 got we=%0b err=%0b exp we=0 err=1", we, load_err);
    end
  endtask

  task automatic test_timeout();
    send_load(5'd10, LW, 2'd0);
    step();
    drive_idle();
    // Sixteen waiting cycles without an error, then the pulse.
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if ({load_pending, load_err, mem_if.mem_ready} !== 3'b100) begin
        tests_failed++;
        $display("FAIL to_wait%0d got pend=%0b err=%0b rdy=%0b exp pend=1 err=0 rdy=0",
                 i, load_pending, load_err, mem_if.mem_ready);
      end
      step();
    end
    tests_run++;
    if ({load_err, we, load_pending, mem_if.mem_ready} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL to_expire got err=%0b we=%0b pend=%0b rdy=%0b exp err=1 we=0 pend=0 rdy=1",
               load_err, we, load_pending, mem_if.mem_ready);
    end
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    step();
    drive_idle();
    tests_run++;
    if ({we, load_err, load_pending} !== 3'b000) begin
      tests_failed++;
      $display("FAIL spurious_rvalid got we=%0b err=%0b pend=%0b exp all 0", we, load_err, load_pending);
    end
  endtask

  task automatic test_rvalid_at_expiry();
    send_load(5'd11, LW, 2'd0);
    step();
    drive_idle();
    repeat (15) step();
    tests_run++;
    if (load_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL expiry_pending got pend=%0b exp 1", load_pending);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    step();
    drive_idle();
    tests_run++;
    if ({we, rd_addr, rd_data, load_err} !== {1'b1, 5'd11, 32'hCAFE_F00D, 1'b0}) begin
      tests_failed++;
      $display("FAIL expiry_data_wins got we=%0b rd=%0d data=%h err=%0b exp we=1 rd=11 data=cafef00d err=0",
               we, rd_addr, rd_data, load_err);
    end
  endtask

  task automatic test_reset_mid_load();
    send_load(5'd12, LW, 2'd0);
    step();
    drive_idle();
    tests_run++;
    if ({load_pending, load_rd_addr} !== {1'b1, 5'd12}) begin
      tests_failed++;
      $display("FAIL pre_reset_pending got pend=%0b lrd=%0d exp pend=1 lrd=12", load_pending, load_rd_addr);
    end
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({we, rd_addr, rd_data, load_pending, load_rd_addr, load_err, mem_if.mem_ready} !==
        {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_load_reset got we=%0b rd=%0d data=%h pend=%0b lrd=%0d err=%0b rdy=%0b exp all 0, rdy=1",
               we, rd_addr, rd_data, load_pending, load_rd_addr, load_err, mem_if.mem_ready);
    end
    rst_n = 1'b1;
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1357_9BDF;
    step();
    drive_idle();
    tests_run++;
    if ({we, load_err, load_pending} !== 3'b000) begin
      tests_failed++;
      $display("FAIL post_reset_rvalid got we=%0b err=%0b pend=%0b exp all 0", we, load_err, load_pending);
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_back_to_back();
    test_load_byte();
    test_load_align();
    test_no_write_cases();
    test_timeout();
    test_rvalid_at_expiry();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
